// File: rtl/req_flag_arbiter_pkg.sv
// Shared definitions for the request-flag arbiter: FSM state encodings and
// the index-width rule used by the round-robin search.
package req_flag_arbiter_pkg;

  // state    | meaning
  // ST_IDLE  | no grant; waiting for a latched request flag
  // ST_GRANT | one requester owns the grant until DONE (or timeout)
  // ST_GAP   | one cycle with all grants low before re-arbitration
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Width of a requester index; never below one bit.
  function automatic int rr_idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_flag_arbiter_rr_pick.sv
// Combinational round-robin selector. The search starts one past the last
// served requester and wraps, so the previous owner is considered last.
module rr_pick
  import req_flag_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = rr_idx_width(N)
) (
  input  logic [N-1:0]  i_pending,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_win,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // First set pending flag after i_last, wrapping at N-1 -> 0.
  always_comb begin
    int          cand;
    logic [IW-1:0] cand_idx;
    o_win    = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(i_last) + off;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!o_any && i_pending[cand_idx]) begin
        o_any           = 1'b1;
        o_win[cand_idx] = 1'b1;
        o_idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/req_flag_arbiter.sv
// Round-robin arbiter with latched request flags and a break-before-make gap
// between grants. All outputs come straight from registers.
// Optional forced release of a stuck grant: define REQ_ARB_TIMEOUT_EN.
// LOG is kept for interface compatibility; no trace logic is built here.
module req_flag_arbiter
  import req_flag_arbiter_pkg::*;
#(
  parameter int BLOCKS  = 4,
  parameter int TIMEOUT = 15,
  parameter int LOG     = 0
) (
  input  logic                      CP,
  input  logic                      MR,
  input  logic [BLOCKS-1:0]         REQ,
  input  logic                      DONE,
  output logic [BLOCKS-1:0]         GNT,
  output logic                      GNT_VALID,
  output logic [$clog2(BLOCKS)-1:0] GNT_ID,
  output logic [BLOCKS-1:0]         PENDING,
  output logic                      TIMEOUT_ERR
);

  localparam int IW = rr_idx_width(BLOCKS);

  logic [1:0]        r_state;
  logic [BLOCKS-1:0] r_pending;
  logic [BLOCKS-1:0] r_gnt;
  logic              r_gnt_valid;
  logic [IW-1:0]     r_gnt_id;
  logic [IW-1:0]     r_last;

  logic [BLOCKS-1:0] w_win;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic              w_timeout;
  logic              w_release;
  logic [BLOCKS-1:0] w_pending_nxt;
  logic              w_unused_cfg;

  assign w_unused_cfg = (LOG != 0) ^ (TIMEOUT != 0);

  rr_pick #(
    .N  (BLOCKS),
    .IW (IW)
  ) u_rr_pick (
    .i_pending (r_pending),
    .i_last    (r_last),
    .o_win     (w_win),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  // Grant ends on DONE or on a forced timeout, but only while granting.
  assign w_release = (r_state == ST_GRANT) && (DONE || w_timeout);

  // Clear the finished owner's flag first, then OR in new requests so a
  // same-edge request from the owner re-queues it.
  assign w_pending_nxt = (r_pending & ~(w_release ? r_gnt : '0)) | REQ;

`ifdef REQ_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_timeout_err;

  assign w_timeout = (r_state == ST_GRANT) && !DONE &&
                     (r_tmo_cnt == CW'(TIMEOUT - 1));

  // Count cycles spent in GRANT; latch a sticky error on forced release.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == ST_GRANT) && !w_release) r_tmo_cnt <= r_tmo_cnt + CW'(1);
      else                                     r_tmo_cnt <= '0;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign TIMEOUT_ERR = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  // Request latching and the IDLE -> GRANT -> GAP sequence.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_last      <= IW'(BLOCKS - 1);
    end else begin
      r_pending <= w_pending_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt       <= w_win;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_idx;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_last      <= r_gnt_id;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_gnt_id    <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign GNT       = r_gnt;
  assign GNT_VALID = r_gnt_valid;
  assign GNT_ID    = r_gnt_id;
  assign PENDING   = r_pending;

endmodule

// File: tb/tb_req_flag_arbiter.sv
// Bench for req_flag_arbiter (BLOCKS=4). Expected grant ids are queued as
// stimulus is applied and compared by a monitor when each new grant appears.
module tb_req_flag_arbiter;

  localparam int NB = 4;

  logic          CP = 1'b0;
  logic          MR = 1'b1;
  logic [NB-1:0] REQ = '0;
  logic          DONE = 1'b0;
  logic [NB-1:0] GNT;
  logic          GNT_VALID;
  logic [1:0]    GNT_ID;
  logic [NB-1:0] PENDING;
  logic          TIMEOUT_ERR;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;
  logic [NB-1:0] exp_gnt;

  req_flag_arbiter #(.BLOCKS(NB), .TIMEOUT(15), .LOG(0)) dut (
    .CP          (CP),
    .MR          (MR),
    .REQ         (REQ),
    .DONE        (DONE),
    .GNT         (GNT),
    .GNT_VALID   (GNT_VALID),
    .GNT_ID      (GNT_ID),
    .PENDING     (PENDING),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every new grant must match the next queued id.
  always @(negedge CP) begin
    if (GNT_VALID && !prev_valid) begin
      chk("sb_has_entry", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        exp_gnt = '0;
        exp_gnt[e] = 1'b1;
        chk("sb_gnt_id", 32'(GNT_ID), 32'(e));
        chk("sb_gnt_onehot", 32'(GNT), 32'(exp_gnt));
      end
    end
    prev_valid = GNT_VALID;
  end

  task automatic do_reset();
    REQ  = '0;
    DONE = 1'b0;
    MR   = 1'b1;
    @(negedge CP);
    MR   = 1'b0;
  endtask

  // Counts low negedges before GNT_VALID appears; bounded.
  task automatic wait_grant(input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge CP);
      if (GNT_VALID) break;
      cyc++;
    end
    chk("grant_seen", 32'(GNT_VALID), 1);
  endtask

  task automatic pulse_done();
    DONE = 1'b1;
    @(posedge CP);
    #1 DONE = 1'b0;
  endtask

  initial begin
    int gap;
    int hold;

    // Reset state
    @(negedge CP);
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_valid", 32'(GNT_VALID), 0);
    chk("rst_id", 32'(GNT_ID), 0);
    chk("rst_pending", 32'(PENDING), 0);
    chk("rst_terr", 32'(TIMEOUT_ERR), 0);
    MR = 1'b0;

    // Single request: PENDING after one edge, grant after the second
    @(posedge CP);
    #1 REQ = 4'b0001;
    exp_q.push_back(0);
    @(posedge CP);
    #1 REQ = '0;
    @(negedge CP);
    chk("lat_pending", 32'(PENDING), 32'h1);
    chk("lat_no_gnt_yet", 32'(GNT_VALID), 0);
    @(negedge CP);
    chk("lat_gnt", 32'(GNT), 32'h1);
    chk("lat_id", 32'(GNT_ID), 0);
    DONE = 1'b1;
    @(posedge CP);
    #1 DONE = 1'b0;
    @(negedge CP);
    chk("rel_gnt", 32'(GNT), 0);
    chk("rel_pending", 32'(PENDING), 0);

    // All requesting: rotation 0,1,2,3,0; owner re-queues on its DONE edge.
    // Between grants GNT stays low through GAP and the IDLE decision edge.
    do_reset();
    REQ = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int g = 0; g < 5; g++) begin
      wait_grant(10, gap);
      if (g > 0) chk("gap_cycles", 32'(gap), 2);
      pulse_done();
    end
    do_reset();

    // Owner re-requests on its DONE edge: it goes behind 2 and 3
    @(posedge CP);
    #1 REQ = 4'b0010;
    exp_q.push_back(1);
    @(posedge CP);
    #1 REQ = '0;
    wait_grant(10, gap);
    REQ = 4'b1100;
    @(posedge CP);
    #1 REQ = '0;
    @(negedge CP);
    chk("hold_pending", 32'(PENDING), 32'hE);
    chk("hold_gnt_stable", 32'(GNT), 32'h2);
    REQ  = 4'b0010;
    DONE = 1'b1;
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1);
    @(posedge CP);
    #1 REQ = '0; DONE = 1'b0;
    @(negedge CP);
    chk("setwins_pending", 32'(PENDING), 32'hE);
    chk("setwins_gnt_low", 32'(GNT), 0);
    for (int g = 0; g < 3; g++) begin
      wait_grant(10, gap);
      pulse_done();
    end
    @(negedge CP);
    chk("drain_pending", 32'(PENDING), 0);

    // Async reset between edges while granting
    do_reset();
    REQ = 4'b0001;
    exp_q.push_back(0);
    @(posedge CP);
    #1 REQ = 4'b1010;
    @(posedge CP);
    #1 REQ = '0;
    wait_grant(10, gap);
    chk("pre_mr_pending", 32'(PENDING), 32'hB);
    #2 MR = 1'b1;
    #1;
    chk("mr_gnt", 32'(GNT), 0);
    chk("mr_valid", 32'(GNT_VALID), 0);
    chk("mr_id", 32'(GNT_ID), 0);
    chk("mr_pending", 32'(PENDING), 0);
    #1 MR = 1'b0;
    @(negedge CP);
    chk("post_mr_idle", 32'(GNT_VALID), 0);

    // DONE while idle with nothing pending changes nothing
    DONE = 1'b1;
    @(posedge CP);
    #1 DONE = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CP);
      chk("idle_done_gnt", 32'(GNT), 0);
      chk("idle_done_pending", 32'(PENDING), 0);
    end
    REQ = 4'b0100;
    exp_q.push_back(2);
    @(posedge CP);
    #1 REQ = '0;
    wait_grant(10, gap);
    pulse_done();

    // Grant held without DONE
    do_reset();
    REQ = 4'b0001;
    exp_q.push_back(0);
    @(posedge CP);
    #1 REQ = '0;
    wait_grant(10, gap);
    hold = 1;
    while (hold < 40) begin
      @(negedge CP);
      if (!GNT_VALID) break;
      hold++;
    end
`ifdef REQ_ARB_TIMEOUT_EN
    chk("timeout_hold", 32'(hold), 15);
    chk("timeout_err_set", 32'(TIMEOUT_ERR), 1);
    repeat (3) @(negedge CP);
    chk("timeout_err_sticky", 32'(TIMEOUT_ERR), 1);
    do_reset();
    chk("timeout_err_clr", 32'(TIMEOUT_ERR), 0);
`else
    chk("no_timeout_hold", 32'(hold), 40);
    chk("no_timeout_err", 32'(TIMEOUT_ERR), 0);
    pulse_done();
    do_reset();
`endif

    repeat (2) @(negedge CP);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/req_flag_arbiter.md
REQ_FLAG_ARBITER -- requirements
Module: req_flag_arbiter

Interface
REQ-001 Parameter BLOCKS, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 15: cycles a grant may be held before forced release (macro-enabled only).
REQ-003 Parameter LOG, default 0: nonzero enables $display trace of state transitions.
REQ-004 Port CP, input, 1: the single clock; all state changes on rising edge.
REQ-005 Port MR, input, 1: reset; asynchronous, active-high.
REQ-006 Port REQ, input, BLOCKS: request level per requester, sampled on CP rise.
REQ-007 Port DONE, input, 1: current grant holder finished; sampled on CP rise.
REQ-008 Port GNT, output, BLOCKS: one-hot grant; all zero when no grant.
REQ-009 Port GNT_VALID, output, 1: high while any GNT bit is high.
REQ-010 Port GNT_ID, output, $clog2(BLOCKS): index of granted requester; 0 when GNT_VALID low.
REQ-011 Port PENDING, output, BLOCKS: latched request flags.
REQ-012 Port TIMEOUT_ERR, output, 1: sticky forced-release flag.

Function
REQ-013 On CP rise with REQ[i]=1, PENDING[i] SHALL be set; it stays set until its grant completes.
REQ-014 FSM states: IDLE, GRANT, GAP; all outputs registered, no combinational path input->output.
REQ-015 IDLE: if any PENDING bit set at a CP rise, select winner and enter GRANT; else stay IDLE.
REQ-016 Winner: round-robin; search starts at LAST+1, wrapping at BLOCKS-1 -> 0; first set PENDING bit wins.
REQ-017 Latency: REQ high at edge k -> PENDING at k -> GNT visible after edge k+1 (2 edges, idle arbiter).
REQ-018 GRANT: GNT/GNT_ID held stable until DONE=1 at a CP rise; then PENDING[GNT_ID] cleared, LAST=GNT_ID, GNT cleared, enter GAP.
REQ-019 Simultaneous clear and REQ[i]=1 for the same i: set wins, PENDING[i] remains 1 (re-queued behind others).
REQ-020 GAP: exactly one cycle with GNT=0 (break-before-make), then IDLE.
REQ-021 DONE in IDLE or GAP SHALL be ignored.
REQ-022 REQ changes during GRANT SHALL NOT change the current winner.

Reset
REQ-023 MR high SHALL immediately (asynchronously) force: state IDLE, GNT=0, GNT_VALID=0, GNT_ID=0, PENDING=0, TIMEOUT_ERR=0, LAST=BLOCKS-1, timeout counter 0.
REQ-024 MR asserted mid-GRANT SHALL drop GNT without passing through GAP; REQ sampling resumes on the first CP rise after MR falls.

Configuration
REQ-025 Macro REQ_ARB_TIMEOUT_EN defined: counter increments each GRANT cycle; on reaching TIMEOUT without DONE, behaves as DONE (REQ-018) and sets TIMEOUT_ERR, sticky until MR.
REQ-026 Macro undefined: no counter logic; grant held indefinitely; TIMEOUT_ERR tied 0; TIMEOUT ignored.

Structure
REQ-027 Shared package holds the FSM state enumeration (IDLE=0, GRANT=1, GAP=2) and the round-robin search width rule.
REQ-028 One sub-module, rr_pick: combinational round-robin selector (PENDING, LAST -> one-hot winner, index, any).

Verification
REQ-029 BLOCKS=4: MR pulse -> all outputs 0, LAST=3; REQ=0001 one cycle -> GNT=0001, GNT_ID=0 two edges later.
REQ-030 REQ=1111 held, DONE pulsed each grant -> grant order 0,1,2,3,0 with one GAP cycle between each.
REQ-031 Grant to 1 held; REQ[1] high on DONE edge -> PENDING[1] stays 1; next grants 2,3 (if pending) before 1.
REQ-032 MR asserted mid-GRANT between edges -> GNT=0000 before next CP rise; PENDING=0000.
REQ-033 REQ_ARB_TIMEOUT_EN, TIMEOUT=15, no DONE -> GNT drops after 15 GRANT cycles, TIMEOUT_ERR=1 until MR.
REQ-034 DONE pulsed in IDLE with PENDING=0000 -> no state change, no outputs toggle.
